// File: rtl/lut_frame_pkg.sv
// Shared definitions for the LUT INIT frame writer: FSM state encoding,
// frame geometry constants and the packed four-word frame type.
package lut_frame_pkg;

  // Default number of 32-bit words in one configuration frame.
  localparam int FRAME_WORDS_DEFAULT = 101;

  // One LUT INIT spans this many consecutive frames of the column.
  localparam int LUT_FRAMES = 4;

  // Width of the slice of a frame word that carries one INIT chunk.
  localparam int FRAME_WORD_W = 16;

  // Writer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } lut_state_e;

  // The four swapped words, index k goes to frame offset k.
  typedef logic [LUT_FRAMES-1:0][FRAME_WORD_W-1:0] frame_words_t;

endpackage

// File: rtl/lut_init_swap.sv
// Purely combinational byte swap of a 64-bit LUT INIT into four 16-bit
// frame words. Word k takes INIT bits [63-16k:48-16k] with its two bytes
// exchanged, so every INIT bit lands in exactly one output bit.
module lut_init_swap
  import lut_frame_pkg::*;
(
  input  logic [63:0]  init_i,
  output frame_words_t words_o
);

  // One swapped word per frame offset.
  for (genvar k = 0; k < LUT_FRAMES; k++) begin : g_word
    assign words_o[k] = {init_i[55-16*k -: 8], init_i[63-16*k -: 8]};
  end

endmodule

// File: rtl/lut_init_frame_writer.sv
// Turns one LUT INIT update request into four frame-buffer writes at
// frame offsets 0..3, all at the same word index and half.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. The source holds its payload stable while valid is high
// and ready is low; valid is never withdrawn before the transfer.
// req_ready is high only in IDLE; wr_valid only in WRITE, and wr_ready
// is ignored whenever wr_valid is low.
//
// Optional build macro LUT_FRAME_WRITER_STATS_EN adds wrapping 16-bit
// counters of done and err pulses (stat_done_cnt, stat_err_cnt).
module lut_init_frame_writer
  import lut_frame_pkg::*;
#(
  parameter int FRAME_WORDS = FRAME_WORDS_DEFAULT,
  parameter int WORD_W      = 7
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [63:0]             req_init,
  input  logic [WORD_W-1:0]       req_word,
  input  logic                    req_half,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [1:0]              wr_frame_ofs,
  output logic [WORD_W-1:0]       wr_word,
  output logic                    wr_half,
  output logic [FRAME_WORD_W-1:0] wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
`ifdef LUT_FRAME_WRITER_STATS_EN
  output logic [15:0]             stat_done_cnt,
  output logic [15:0]             stat_err_cnt,
`endif
  output logic [1:0]              dbg_state
);

  // Highest legal word index; anything above it is rejected.
  localparam logic [WORD_W-1:0] MAX_WORD = WORD_W'(FRAME_WORDS - 1);

  lut_state_e               state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  frame_words_t             words_q, words_d;
  logic [WORD_W-1:0]        word_q, word_d;
  logic                     half_q, half_d;
  logic                     req_ready_q, req_ready_d;
  logic                     wr_valid_q, wr_valid_d;
  logic [1:0]               wr_ofs_q, wr_ofs_d;
  logic [FRAME_WORD_W-1:0]  wr_data_q, wr_data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  frame_words_t             swap_words;

  lut_init_swap u_swap (
    .init_i  (req_init),
    .words_o (swap_words)
  );

  // Next-state logic; every output is derived from the next state so
  // that all outputs leave the block straight from flops.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    words_d = words_q;
    word_d  = word_q;
    half_d  = half_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          word_d = req_word;
          half_d = req_half;
          if (req_word > MAX_WORD) begin
            state_d = ST_ERR;
          end else begin
            words_d = swap_words;
            idx_d   = 2'd0;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (wr_ready) begin
          if (idx_q == 2'd3) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    wr_valid_d  = (state_d == ST_WRITE);
    wr_ofs_d    = idx_d;
    wr_data_d   = words_d[idx_d];
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERR);
  end

  // State and registered outputs; reset abandons any sequence in flight.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      words_q     <= '0;
      word_q      <= '0;
      half_q      <= 1'b0;
      req_ready_q <= 1'b1;
      wr_valid_q  <= 1'b0;
      wr_ofs_q    <= 2'd0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      words_q     <= words_d;
      word_q      <= word_d;
      half_q      <= half_d;
      req_ready_q <= req_ready_d;
      wr_valid_q  <= wr_valid_d;
      wr_ofs_q    <= wr_ofs_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

`ifdef LUT_FRAME_WRITER_STATS_EN
  logic [15:0] stat_done_q, stat_err_q;

  // Event counters, updated on the edge that raises each pulse; they wrap.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stat_done_q <= 16'd0;
      stat_err_q  <= 16'd0;
    end else begin
      if (done_d) stat_done_q <= stat_done_q + 16'd1;
      if (err_d)  stat_err_q  <= stat_err_q + 16'd1;
    end
  end

  assign stat_done_cnt = stat_done_q;
  assign stat_err_cnt  = stat_err_q;
`endif

  assign req_ready    = req_ready_q;
  assign wr_valid     = wr_valid_q;
  assign wr_frame_ofs = wr_ofs_q;
  assign wr_word      = word_q;
  assign wr_half      = half_q;
  assign wr_data      = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_lut_init_frame_writer.sv
// Bench for lut_init_frame_writer: directed requests with hand-computed
// frame words, a write scoreboard fed by the driver and drained by an
// independent monitor, plus pulse/handshake bookkeeping.
module tb_lut_init_frame_writer;

  localparam int WORD_W = 7;
  localparam int EW     = 2 + WORD_W + 1 + 16;

  logic              Clk;
  logic              Rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [63:0]       req_init;
  logic [WORD_W-1:0] req_word;
  logic              req_half;
  logic              wr_valid;
  logic              wr_ready;
  logic [1:0]        wr_frame_ofs;
  logic [WORD_W-1:0] wr_word;
  logic              wr_half;
  logic [15:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        dbg_state;
`ifdef LUT_FRAME_WRITER_STATS_EN
  logic [15:0]       stat_done_cnt;
  logic [15:0]       stat_err_cnt;
`endif

  lut_init_frame_writer #(.FRAME_WORDS(101), .WORD_W(WORD_W)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_init     (req_init),
    .req_word     (req_word),
    .req_half     (req_half),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_frame_ofs (wr_frame_ofs),
    .wr_word      (wr_word),
    .wr_half      (wr_half),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .err          (err),
`ifdef LUT_FRAME_WRITER_STATS_EN
    .stat_done_cnt(stat_done_cnt),
    .stat_err_cnt (stat_err_cnt),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int hs_cnt = 0;
  int valid_cycles = 0;
  int stall_n = 0;
  bit hs_pending = 0;
  bit prev_stall = 0;
  logic [EW-1:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  always @(negedge Clk) begin
    logic [EW-1:0] cur;
    cur = {wr_frame_ofs, wr_word, wr_half, wr_data};
    if (done) done_cnt++;
    if (err)  err_cnt++;
    if (Rst_n && wr_valid) begin
      valid_cycles++;
      if (prev_stall) check("stall_hold", 64'(cur), 64'(held));
      if (wr_ready) begin
        hs_cnt++;
        hs_pending = 1;
        prev_stall = 0;
        if (exp_q.size() == 0) check("unexpected_write", 64'(cur), 64'hDEAD);
        else check("write", 64'(cur), 64'(exp_q.pop_front()));
      end else begin
        held = cur;
        prev_stall = 1;
        hs_pending = 0;
      end
    end else begin
      if (prev_stall) check("valid_dropped", 64'(wr_valid), 64'd1);
      prev_stall = 0;
      hs_pending = 0;
    end
  end

  // ---------------- wr_ready driver ----------------
  initial begin
    int cnt;
    cnt = 0;
    wr_ready = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      if (hs_pending || !wr_valid) begin
        cnt = 0;
        wr_ready = (stall_n == 0);
      end else if (!wr_ready) begin
        cnt++;
        if (cnt >= stall_n) wr_ready = 1'b1;
      end
    end
  end

  // ---------------- request driver tasks ----------------
  task automatic push_exp(input logic [WORD_W-1:0] w, input logic h, input logic [63:0] d);
    for (int k = 0; k < 4; k++)
      exp_q.push_back({2'(k), w, h, d[63-16*k -: 16]});
  endtask

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (!req_ready && t < 200) begin
      @(posedge Clk); #1; t++;
    end
    if (!req_ready) check(name, 64'(req_ready), 64'd1);
  endtask

  // exp_words packs the hand-computed ofs0..ofs3 data, ofs0 in the top 16 bits.
  task automatic do_req(input logic [63:0] init, input logic [WORD_W-1:0] w,
                        input logic h, input logic [63:0] exp_words, input bit good);
    wait_ready("req_ready_timeout");
    if (good) push_exp(w, h, exp_words);
    req_init  = init;
    req_word  = w;
    req_half  = h;
    req_valid = 1'b1;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    req_init  = '0;
    req_word  = '0;
    req_half  = 1'b0;
  endtask

  task automatic run_req(input string name, input logic [63:0] init, input logic [WORD_W-1:0] w,
                         input logic h, input logic [63:0] exp_words, input bit good);
    int d0, e0, v0;
    d0 = done_cnt; e0 = err_cnt; v0 = valid_cycles;
    do_req(init, w, h, exp_words, good);
    wait_ready({name, "_finish_timeout"});
    @(negedge Clk);
    check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_done_pulses"}, 64'(done_cnt - d0), good ? 64'd1 : 64'd0);
    check({name, "_err_pulses"}, 64'(err_cnt - e0), good ? 64'd0 : 64'd1);
    if (!good) check({name, "_valid_cycles"}, 64'(valid_cycles - v0), 64'd0);
    @(posedge Clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int h0;
    Rst_n = 1'b0;
    req_valid = 1'b0;
    req_init = '0;
    req_word = '0;
    req_half = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_wr_valid", 64'(wr_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_err", 64'({done, err}), 64'd0);
    check("rst_wr_fields", 64'({wr_frame_ofs, wr_word, wr_half, wr_data}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Basic sequence with latency checks.
    stall_n = 0;
    h0 = hs_cnt;
    do_req(64'h0123456789ABCDEF, 7'd10, 1'b1, 64'h2301_6745_AB89_EFCD, 1'b1);
    check("lat_first_valid", 64'({wr_valid, busy, req_ready}), 64'b110);
    repeat (4) begin @(posedge Clk); #1; end
    check("lat_done_cycle", 64'({done, wr_valid, req_ready}), 64'b100);
    @(posedge Clk); #1;
    check("lat_back_idle", 64'({req_ready, done, busy}), 64'b100);
    check("basic_handshakes", 64'(hs_cnt - h0), 64'd4);
    check("basic_queue_left", 64'(exp_q.size()), 64'd0);

    // Second pattern, lower half.
    run_req("pattern2", 64'h1122334455667788, 7'd0, 1'b0, 64'h2211_4433_6655_8877, 1'b1);

    // Backpressure: wr_ready low before every word.
    stall_n = 3;
    h0 = hs_cnt;
    run_req("backpressure", 64'h0123456789ABCDEF, 7'd10, 1'b1, 64'h2301_6745_AB89_EFCD, 1'b1);
    check("bp_handshakes", 64'(hs_cnt - h0), 64'd4);
    stall_n = 0;

    // Range boundaries.
    run_req("word_max", 64'hFEDCBA9876543210, 7'd100, 1'b0, 64'hDCFE_98BA_5476_1032, 1'b1);
    run_req("word_over", 64'hFEDCBA9876543210, 7'd101, 1'b1, 64'h0, 1'b0);
    run_req("word_127", 64'h0, 7'd127, 1'b0, 64'h0, 1'b0);

    // Bit isolation.
    run_req("bit63", 64'h8000000000000000, 7'd5, 1'b0, 64'h0080_0000_0000_0000, 1'b1);
    run_req("bit0", 64'h0000000000000001, 7'd5, 1'b1, 64'h0000_0000_0000_0100, 1'b1);

    // Reset after the second write handshake.
    h0 = done_cnt;
    do_req(64'hAAAA5555CCCC3333, 7'd20, 1'b0, 64'hAAAA_5555_CCCC_3333, 1'b1);
    @(posedge Clk); @(posedge Clk); #1;
    Rst_n = 1'b0;
    #1;
    check("rstmid_wr_valid", 64'(wr_valid), 64'd0);
    check("rstmid_two_left", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    check("rstmid_idle", 64'({req_ready, busy, dbg_state}), 64'b1000);
    check("rstmid_no_done", 64'(done_cnt - h0), 64'd0);
    run_req("after_reset", 64'h0123456789ABCDEF, 7'd3, 1'b1, 64'h2301_6745_AB89_EFCD, 1'b1);

`ifdef LUT_FRAME_WRITER_STATS_EN
    // Counters restart from the mid-run reset: one good run since then.
    run_req("st_g1", 64'h1, 7'd1, 1'b0, 64'h0000_0000_0000_0100, 1'b1);
    run_req("st_b0", 64'h1, 7'd110, 1'b0, 64'h0, 1'b0);
    run_req("st_g2", 64'h1, 7'd2, 1'b0, 64'h0000_0000_0000_0100, 1'b1);
    run_req("st_b1", 64'h1, 7'd111, 1'b0, 64'h0, 1'b0);
    check("stat_done_cnt", 64'(stat_done_cnt), 64'd3);
    check("stat_err_cnt", 64'(stat_err_cnt), 64'd2);
`endif

    repeat (3) @(posedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
